// File: rtl/ring_sequence_checker_pkg.sv
// ring_sequence_checker shared types
// FSM state encoding and ring rotate helper
package ring_sequence_checker_pkg;

  typedef enum logic [1:0] {
    LOCK_WAIT = 2'd0,
    LOCKED    = 2'd1,
    FAULT     = 2'd2
  } ring_state_e;

  // Widest ring the rotate helper supports
  localparam int MAXW = 32;
  localparam int MAXB = 5;

  // Single-step rotation of the low w bits of r
  function automatic logic [MAXW-1:0] ring_rotate(
    input logic [MAXW-1:0] r,
    input int              w,
    input logic            left
  );
    logic [MAXW-1:0] o;
    o = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < w) begin
        if (left) begin
          o[i] = (i == 0) ? r[MAXB'(w - 1)]
                          : r[MAXB'((i + MAXW - 1) % MAXW)];
        end else begin
          o[i] = (i == w - 1) ? r[0]
                              : r[MAXB'((i + 1) % MAXW)];
        end
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// ring_onehot_enc
// Strict one-hot test plus binary index of the set bit
module ring_onehot_enc #(
  parameter  int WIDTH = 4,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic             is_onehot,
  output logic [IW-1:0]    index
);

  // Exactly one bit set: nonzero and clearing the low bit leaves zero
  always_comb begin
    is_onehot = (word != '0) &&
                ((word & (word - 1'b1)) == '0);
  end

  // OR of set-bit positions; exact only for one-hot words
  always_comb begin
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (word[i]) begin
        index = index | IW'(i);
      end
    end
  end

endmodule

// File: rtl/ring_sequence_checker.sv
// ring_sequence_checker
// Locks onto a one-hot ring, checks rotation, counts faults/revs
module ring_sequence_checker
  import ring_sequence_checker_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CNT_W    = 8,
  parameter  int ROT_LEFT = 1,
  localparam int IW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             en,
  input  logic             err_clr,
  output logic [IW-1:0]    idx,
  output logic             locked,
  output logic             seq_err,
  output logic [CNT_W-1:0] rev_count,
  output logic [CNT_W-1:0] err_count
);

  // Bit position that closes one revolution
  localparam int WRAP = (ROT_LEFT != 0) ? 0 : WIDTH - 1;

  ring_state_e      state_q;
  ring_state_e      state_d;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_nxt;
  logic [IW-1:0]    idx_q;
  logic [CNT_W-1:0] rev_q;
  logic [CNT_W-1:0] err_q;
  logic             oh;
  logic [IW-1:0]    enc_idx;
  logic             take;
  logic             rev_inc;
  logic             err_inc;

  ring_onehot_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .word      (ring_in),
    .is_onehot (oh),
    .index     (enc_idx)
  );

  // Expected successor of the sampled word
  always_comb begin
    exp_nxt = WIDTH'(ring_rotate(MAXW'(ring_in), WIDTH,
                                 ROT_LEFT != 0));
  end

  // Next state and per-edge update strobes
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    rev_inc = 1'b0;
    err_inc = 1'b0;
    unique case (state_q)
      LOCK_WAIT: begin
        if (en && oh) begin
          state_d = LOCKED;
          take    = 1'b1;
        end
      end
      LOCKED: begin
        if (en) begin
          if (ring_in == exp_q) begin
            take    = 1'b1;
            rev_inc = ring_in[WRAP];
          end else begin
            state_d = FAULT;
            err_inc = 1'b1;
          end
        end
      end
      FAULT: begin
        if (err_clr) begin
          state_d = LOCK_WAIT;
        end
      end
      default: begin
        state_d = LOCK_WAIT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOCK_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Accepted word: capture index and next expected word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      exp_q <= '0;
    end else if (take) begin
      idx_q <= enc_idx;
      exp_q <= exp_nxt;
    end
  end

  // Saturating revolution counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rev_q <= '0;
    end else if (rev_inc && (rev_q != '1)) begin
      rev_q <= rev_q + 1'b1;
    end
  end

  // Saturating fault counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (err_inc && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign idx       = idx_q;
  assign locked    = (state_q == LOCKED);
  assign seq_err   = (state_q == FAULT);
  assign rev_count = rev_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// tb_ring_sequence_checker
// Directed stimulus, behavioural model, per-cycle compare
module tb_ring_sequence_checker;

  logic       clk;
  logic       reset;
  logic [3:0] ring_in;
  logic       en;
  logic       err_clr;

  logic [1:0] idx1;
  logic       locked1;
  logic       seq_err1;
  logic [7:0] rev1;
  logic [7:0] err1;

  logic [1:0] idx2;
  logic       locked2;
  logic       seq_err2;
  logic [1:0] rev2;
  logic [1:0] err2;

  int n_cmp = 0;
  int n_bad = 0;

  ring_sequence_checker dut (
    .clk       (clk),
    .reset     (reset),
    .ring_in   (ring_in),
    .en        (en),
    .err_clr   (err_clr),
    .idx       (idx1),
    .locked    (locked1),
    .seq_err   (seq_err1),
    .rev_count (rev1),
    .err_count (err1)
  );

  ring_sequence_checker #(
    .WIDTH (4),
    .CNT_W (2)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .ring_in   (ring_in),
    .en        (en),
    .err_clr   (err_clr),
    .idx       (idx2),
    .locked    (locked2),
    .seq_err   (seq_err2),
    .rev_count (rev2),
    .err_count (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // st: 0 waiting for lock, 1 locked, 2 faulted
  typedef struct {
    int st;
    int idx;
    int nxt;
    int rev;
    int err;
  } mdl_t;

  mdl_t m1;
  mdl_t m2;

  function automatic mdl_t mstep(mdl_t m, logic e,
                                 logic [3:0] r, logic c,
                                 int cmax);
    bit good;
    good = ($countones(r) == 1);
    if (m.st == 2) begin
      if (c) m.st = 0;
    end else if (e) begin
      if (m.st == 0) begin
        if (good) begin
          m.st  = 1;
          m.idx = $clog2(r);
          m.nxt = (m.idx + 1) % 4;
        end
      end else if (good && $clog2(r) == m.nxt) begin
        m.idx = m.nxt;
        m.nxt = (m.idx + 1) % 4;
        if (m.idx == 0 && m.rev < cmax) m.rev++;
      end else begin
        m.st = 2;
        if (m.err < cmax) m.err++;
      end
    end
    return m;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m1 = '{0, 0, 0, 0, 0};
      m2 = '{0, 0, 0, 0, 0};
    end else begin
      m1 = mstep(m1, en, ring_in, err_clr, 255);
      m2 = mstep(m2, en, ring_in, err_clr, 3);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("d1.locked", 32'(locked1), 32'(m1.st == 1));
    chk("d1.seq_err", 32'(seq_err1), 32'(m1.st == 2));
    chk("d1.idx", 32'(idx1), m1.idx);
    chk("d1.rev", 32'(rev1), m1.rev);
    chk("d1.err", 32'(err1), m1.err);
    chk("d2.locked", 32'(locked2), 32'(m2.st == 1));
    chk("d2.seq_err", 32'(seq_err2), 32'(m2.st == 2));
    chk("d2.idx", 32'(idx2), m2.idx);
    chk("d2.rev", 32'(rev2), m2.rev);
    chk("d2.err", 32'(err2), m2.err);
  end

  task automatic cyc(input logic e, input logic [3:0] r,
                     input logic c);
    en      = e;
    ring_in = r;
    err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input int l, input int s,
                     input int i, input int rv, input int er);
    chk({nm, ".locked"}, 32'(locked1), l);
    chk({nm, ".seq_err"}, 32'(seq_err1), s);
    chk({nm, ".idx"}, 32'(idx1), i);
    chk({nm, ".rev"}, 32'(rev1), rv);
    chk({nm, ".err"}, 32'(err1), er);
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    ring_in = 4'b0000;
    err_clr = 1'b0;
    #50;
    lit("rst", 0, 0, 0, 0, 0);
    #50;
    reset = 1'b0;

    cyc(1, 4'b0001, 0); lit("lk0", 1, 0, 0, 0, 0);
    cyc(1, 4'b0010, 0); lit("lk1", 1, 0, 1, 0, 0);
    cyc(1, 4'b0100, 0); lit("lk2", 1, 0, 2, 0, 0);
    cyc(1, 4'b1000, 0); lit("lk3", 1, 0, 3, 0, 0);
    cyc(1, 4'b0001, 0); lit("wrap", 1, 0, 0, 1, 0);

    cyc(1, 4'b0010, 0); lit("pre", 1, 0, 1, 1, 0);
    cyc(1, 4'b1000, 0); lit("skip", 0, 1, 1, 1, 1);
    cyc(1, 4'b0100, 0); lit("ign1", 0, 1, 1, 1, 1);
    cyc(1, 4'b0001, 0); lit("ign2", 0, 1, 1, 1, 1);
    cyc(0, 4'b0000, 1); lit("clr", 0, 0, 1, 1, 1);
    cyc(1, 4'b0100, 0); lit("relk", 1, 0, 2, 1, 1);

    cyc(1, 4'b0100, 0); lit("rep", 0, 1, 2, 1, 2);
    cyc(1, 4'b0001, 1); lit("clr2", 0, 0, 2, 1, 2);
    cyc(1, 4'b0000, 0); lit("zero", 0, 0, 2, 1, 2);
    cyc(1, 4'b0110, 0); lit("multi", 0, 0, 2, 1, 2);
    cyc(1, 4'b0100, 0); lit("lk4", 1, 0, 2, 1, 2);

    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b1111, 0);
      lit("hold", 1, 0, 2, 1, 2);
    end
    cyc(1, 4'b1000, 0); lit("resume", 1, 0, 3, 1, 2);
    cyc(1, 4'b0001, 0); lit("wrap2", 1, 0, 0, 2, 2);
    cyc(1, 4'b0010, 0);

    #2 reset = 1'b1;
    #1 lit("mid", 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    cyc(1, 4'b0100, 0); lit("postrst", 1, 0, 2, 0, 0);

    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'b1000, 0);
      cyc(1, 4'b0001, 0);
      cyc(1, 4'b0010, 0);
      cyc(1, 4'b0100, 0);
    end
    lit("revs", 1, 0, 2, 5, 0);
    chk("d2.revsat", 32'(rev2), 3);

    for (int k = 0; k < 5; k++) begin
      cyc(1, 4'b0000, 0);
      cyc(0, 4'b0000, 1);
      cyc(1, 4'b0001, 0);
    end
    lit("errs", 1, 0, 0, 5, 5);
    chk("d2.errsat", 32'(err2), 3);
    chk("d2.revkeep", 32'(rev2), 3);

    cyc(1, 4'b0010, 1); lit("clrlk", 1, 0, 1, 5, 5);
    cyc(0, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
